// File: rtl/processor_pkg.sv
// ============================================================================
// Package  : processor_pkg
// Purpose  : Shared types and default sizes for the 5-stage pipeline control.
// Revision : 1.0
// ============================================================================
`default_nettype none

package processor_pkg;

   localparam int REG_W_DEF   = 5;
   localparam int CNT_W_DEF   = 16;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      BUBBLE  = 2'd1,
      FLUSHED = 2'd2,
      FREEZE  = 2'd3
   } hz_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with synchronous active-low clear; sticks at all-ones.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             clr_n_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!clr_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// Module   : hazard_controller
// Purpose  : Per-cycle advance/stall/flush/freeze decisions for the pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_controller
   import processor_pkg::*;
#(
   parameter int REG_W   = REG_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [REG_W-1:0] rs_IFID,
   input  logic [REG_W-1:0] rt_IFID,
   input  logic             memRead_IDEX,
   input  logic [REG_W-1:0] rt_IDEX,
   input  logic             PCSrc_MEM,
   input  logic             memBusy,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             hazardMux,
   output logic             flushIFID,
   output logic             flushIDEX,
   output logic             flushEXMEM,
   output logic             freeze,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount,
   output logic             memTimeout
);

   localparam int                BUSY_W    = $clog2(TIMEOUT + 1);
   localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(TIMEOUT - 1);

   hz_state_e         state_q;
   hz_state_e         state_d;
   logic              timeout_q;
   logic              timeout_d;
   logic              lu_hit;
   logic              lu_enable;
   logic              stall_inc;
   logic              flush_inc;
   logic              busy_inc;
   logic              busy_clr_n;
   logic [BUSY_W-1:0] busy_cnt;

   assign lu_hit = memRead_IDEX && (rt_IDEX != '0) &&
                   ((rt_IDEX == rs_IFID) || (rt_IDEX == rt_IFID));

   // After a bubble or flush the stage feeding the compare holds a NOP.
   assign lu_enable = (state_q == RUN) || (state_q == FREEZE);

   always_comb begin
      state_d    = RUN;
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      hazardMux  = 1'b0;
      flushIFID  = 1'b0;
      flushIDEX  = 1'b0;
      flushEXMEM = 1'b0;
      freeze     = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;

      if (memBusy) begin
         freeze    = 1'b1;
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         state_d   = FREEZE;
      end else if (PCSrc_MEM) begin
         flushIFID  = 1'b1;
         flushIDEX  = 1'b1;
         flushEXMEM = 1'b1;
         flush_inc  = 1'b1;
         state_d    = FLUSHED;
      end else if (lu_hit && lu_enable) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         hazardMux = 1'b1;
         stall_inc = 1'b1;
         state_d   = BUBBLE;
      end

      if (!reset_n) begin
         state_d    = RUN;
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         hazardMux  = 1'b1;
         flushIFID  = 1'b1;
         flushIDEX  = 1'b1;
         flushEXMEM = 1'b1;
         freeze     = 1'b0;
         stall_inc  = 1'b0;
         flush_inc  = 1'b0;
      end
   end

   assign busy_inc   = (state_q == FREEZE) && memBusy;
   assign busy_clr_n = reset_n && memBusy;
   assign timeout_d  = timeout_q || (busy_inc && (busy_cnt >= BUSY_LAST));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= RUN;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= timeout_d;
      end
   end

   assign memTimeout = timeout_q;

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clock   (clock),
      .clr_n_i (reset_n),
      .inc_i   (stall_inc),
      .count_o (stallCount)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clock   (clock),
      .clr_n_i (reset_n),
      .inc_i   (flush_inc),
      .count_o (flushCount)
   );

   sat_counter #(.WIDTH(BUSY_W)) u_busy_cnt (
      .clock   (clock),
      .clr_n_i (busy_clr_n),
      .inc_i   (busy_inc),
      .count_o (busy_cnt)
   );

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// Module   : tb_hazard_controller
// Purpose  : Directed self-checking bench for hazard_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_controller;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [4:0]  rs_IFID, rt_IFID, rt_IDEX;
   logic        memRead_IDEX, PCSrc_MEM, memBusy;

   logic        PCWrite, IFIDWrite, hazardMux, flushIFID, flushIDEX, flushEXMEM;
   logic        freeze, memTimeout;
   logic [15:0] stallCount, flushCount;

   logic        s_PCWrite, s_IFIDWrite, s_hazardMux, s_flushIFID, s_flushIDEX;
   logic        s_flushEXMEM, s_freeze, s_memTimeout;
   logic [3:0]  s_stallCount, s_flushCount;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   hazard_controller u_dut (
      .clock(clock), .reset_n(reset_n), .rs_IFID(rs_IFID), .rt_IFID(rt_IFID),
      .memRead_IDEX(memRead_IDEX), .rt_IDEX(rt_IDEX), .PCSrc_MEM(PCSrc_MEM),
      .memBusy(memBusy), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
      .hazardMux(hazardMux), .flushIFID(flushIFID), .flushIDEX(flushIDEX),
      .flushEXMEM(flushEXMEM), .freeze(freeze), .stallCount(stallCount),
      .flushCount(flushCount), .memTimeout(memTimeout)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   hazard_controller #(.CNT_W(4)) u_dut_sat (
      .clock(clock), .reset_n(reset_n), .rs_IFID(rs_IFID), .rt_IFID(rt_IFID),
      .memRead_IDEX(memRead_IDEX), .rt_IDEX(rt_IDEX), .PCSrc_MEM(PCSrc_MEM),
      .memBusy(memBusy), .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite),
      .hazardMux(s_hazardMux), .flushIFID(s_flushIFID), .flushIDEX(s_flushIDEX),
      .flushEXMEM(s_flushEXMEM), .freeze(s_freeze), .stallCount(s_stallCount),
      .flushCount(s_flushCount), .memTimeout(s_memTimeout)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic clear_inputs();
      rs_IFID = '0; rt_IFID = '0; rt_IDEX = '0;
      memRead_IDEX = 1'b0; PCSrc_MEM = 1'b0; memBusy = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      memRead_IDEX = 1'b1; rt_IDEX = rd; rs_IFID = rs; rt_IFID = rt;
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      set_lu(5'd3, 5'd3, 5'd0);
      tick();
      tick();
      chk_eq("rst_pcwrite",   PCWrite,    0);
      chk_eq("rst_ifidwrite", IFIDWrite,  0);
      chk_eq("rst_hazardmux", hazardMux,  1);
      chk_eq("rst_flushes",   {flushIFID, flushIDEX, flushEXMEM}, 3'b111);
      chk_eq("rst_freeze",    freeze,     0);
      chk_eq("rst_stallcnt",  stallCount, 0);
      chk_eq("rst_flushcnt",  flushCount, 0);
      chk_eq("rst_timeout",   memTimeout, 0);

      clear_inputs();
      reset_n = 1'b1;
      #1;
      chk_eq("run_pcwrite",   PCWrite,   1);
      chk_eq("run_ifidwrite", IFIDWrite, 1);
      chk_eq("run_hazardmux", hazardMux, 0);
      chk_eq("run_flushes",   {flushIFID, flushIDEX, flushEXMEM}, 3'b000);

      // Load-use on rs, held for two cycles: exactly one bubble.
      set_lu(5'd3, 5'd3, 5'd0);
      #1;
      chk_eq("lu_pcwrite",   PCWrite,   0);
      chk_eq("lu_ifidwrite", IFIDWrite, 0);
      chk_eq("lu_hazardmux", hazardMux, 1);
      tick();
      chk_eq("lu_stallcnt",  stallCount, 1);
      chk_eq("lu_held_pcwrite",   PCWrite,   1);
      chk_eq("lu_held_hazardmux", hazardMux, 0);
      tick();
      chk_eq("lu_held_stallcnt",  stallCount, 1);

      set_lu(5'd0, 5'd0, 5'd0);
      #1;
      chk_eq("r0_hazardmux", hazardMux, 0);
      chk_eq("r0_pcwrite",   PCWrite,   1);
      tick();
      chk_eq("r0_stallcnt",  stallCount, 1);

      set_lu(5'd5, 5'd1, 5'd5);
      #1;
      chk_eq("lu_rt_hazardmux", hazardMux, 1);
      tick();
      chk_eq("lu_rt_stallcnt", stallCount, 2);
      clear_inputs();
      tick();
      rt_IDEX = 5'd3; rs_IFID = 5'd3;
      #1;
      chk_eq("nomemread_hazardmux", hazardMux, 0);

      // Taken branch beats a simultaneous load-use.
      set_lu(5'd3, 5'd3, 5'd0);
      PCSrc_MEM = 1'b1;
      #1;
      chk_eq("br_flushes",   {flushIFID, flushIDEX, flushEXMEM}, 3'b111);
      chk_eq("br_pcwrite",   PCWrite,   1);
      chk_eq("br_hazardmux", hazardMux, 0);
      tick();
      chk_eq("br_flushcnt", flushCount, 1);
      chk_eq("br_stallcnt", stallCount, 2);
      PCSrc_MEM = 1'b0;
      #1;
      chk_eq("br_next_hazardmux", hazardMux, 0);
      chk_eq("br_next_pcwrite",   PCWrite,   1);
      tick();
      chk_eq("br_next_stallcnt", stallCount, 2);
      clear_inputs();
      tick();

      // Freeze overrides a pending branch for exactly the busy cycles.
      memBusy = 1'b1; PCSrc_MEM = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_eq("frz_freeze",  freeze, 1);
         chk_eq("frz_flushes", {flushIFID, flushIDEX, flushEXMEM}, 3'b000);
         chk_eq("frz_pcwrite", PCWrite, 0);
         tick();
      end
      chk_eq("frz_flushcnt_hold", flushCount, 1);
      memBusy = 1'b0;
      #1;
      chk_eq("frz_rel_freeze",  freeze, 0);
      chk_eq("frz_rel_flushes", {flushIFID, flushIDEX, flushEXMEM}, 3'b111);
      tick();
      chk_eq("frz_rel_flushcnt", flushCount, 2);
      chk_eq("frz_short_timeout", memTimeout, 0);
      clear_inputs();
      tick();

      // Long busy period trips the sticky timeout.
      memBusy = 1'b1;
      for (int i = 0; i < 256; i++) tick();
      chk_eq("to_set", memTimeout, 1);
      memBusy = 1'b0;
      #1;
      chk_eq("to_rel_freeze", freeze, 0);
      tick();
      tick();
      chk_eq("to_sticky", memTimeout, 1);

      // Saturation on the 4-bit instance: 20 bubbles into a 15-max counter.
      set_lu(5'd7, 5'd7, 5'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         tick();
      end
      chk_eq("sat_small_stallcnt", s_stallCount, 15);
      chk_eq("sat_wide_stallcnt",  stallCount,   22);
      #1;
      chk_eq("sat_small_hit", s_hazardMux, 1);
      tick();
      chk_eq("sat_small_hold", s_stallCount, 15);
      chk_eq("sat_small_flushcnt", s_flushCount, 2);
      clear_inputs();
      tick();

      // Reset asserted while frozen.
      memBusy = 1'b1;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk_eq("rstfrz_freeze",    freeze,    0);
      chk_eq("rstfrz_hazardmux", hazardMux, 1);
      tick();
      chk_eq("rstfrz_stallcnt", stallCount, 0);
      chk_eq("rstfrz_flushcnt", flushCount, 0);
      chk_eq("rstfrz_timeout",  memTimeout, 0);
      reset_n = 1'b1;
      memBusy = 1'b0;
      #1;
      chk_eq("rstfrz_run_pcwrite", PCWrite, 1);
      chk_eq("rstfrz_run_freeze",  freeze,  0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage 16-bit processor. Decides every cycle whether each stage advances, stalls or is flushed: load-use bubbles (drives `IFIDWrite`, PC write enable and the `hazardMux` select of `muxControle`), taken-branch flushes (branch resolves in MEM via `PCSrc`), and whole-pipeline freeze while data memory is busy. Keeps saturating stall/flush counters and a sticky memory-timeout flag for debug.

## Interface
Parameters:
- `REG_W`, 5, register-address width
- `CNT_W`, 16, width of the performance counters
- `TIMEOUT`, 255, max consecutive `memBusy` cycles before `memTimeout` sets

Ports:
- `clock`  in  1  rising-edge clock; one clock only
- `reset_n`  in  1  synchronous, active-low reset
- `rs_IFID`  in  REG_W  rs field of instruction in IF/ID
- `rt_IFID`  in  REG_W  rt field of instruction in IF/ID
- `memRead_IDEX`  in  1  MemRead of instruction in ID/EX
- `rt_IDEX`  in  REG_W  rt (load destination) in ID/EX
- `PCSrc_MEM`  in  1  branch taken, resolved in MEM
- `memBusy`  in  1  data memory access in MEM not complete
- `PCWrite`  out  1  PC load enable
- `IFIDWrite`  out  1  IF/ID load enable
- `hazardMux`  out  1  1 = zero control signals entering ID/EX (bubble)
- `flushIFID`, `flushIDEX`, `flushEXMEM`  out  1 each  clear stage register to NOP at next edge
- `freeze`  out  1  all pipeline registers hold
- `stallCount`  out  CNT_W  load-use bubbles inserted
- `flushCount`  out  CNT_W  taken-branch flushes
- `memTimeout`  out  1  sticky: memBusy exceeded TIMEOUT

## Operation
- FSM states: RUN, BUBBLE, FLUSHED, FREEZE. Reset state RUN.
- Load-use hit = `memRead_IDEX` & `rt_IDEX != 0` & (`rt_IDEX == rs_IFID` | `rt_IDEX == rt_IFID`). Register 0 never hazards.
- Priority each cycle: `memBusy` > `PCSrc_MEM` > load-use.
- RUN: default outputs `PCWrite=1`, `IFIDWrite=1`, `hazardMux=0`, flushes 0, `freeze=0`.
  - `memBusy` → freeze outputs, next FREEZE.
  - `PCSrc_MEM` → all three flushes 1, `PCWrite=1` (loads branch target), `flushCount`++, next FLUSHED.
  - load-use hit → `PCWrite=0`, `IFIDWrite=0`, `hazardMux=1`, `stallCount`++, next BUBBLE.
- BUBBLE: default outputs; load-use detection suppressed (ID/EX holds the bubble); `PCSrc_MEM`/`memBusy` handled as in RUN; else next RUN.
- FLUSHED: default outputs; load-use suppressed (IF/ID is a NOP); `memBusy`/`PCSrc_MEM` handled as in RUN; else next RUN.
- FREEZE: `freeze=1`, `PCWrite=0`, `IFIDWrite=0`, `hazardMux=0`, flushes 0. Busy counter increments each cycle; reaching TIMEOUT sets `memTimeout` (sticky until reset). `memBusy` low → next RUN, busy counter cleared; a pending `PCSrc_MEM` / load-use is re-evaluated in RUN the following cycle (inputs are held by the frozen pipeline).
- Counters saturate at all-ones; never wrap.

## Timing
- Control outputs are Mealy: combinational from state and current inputs, acted on by pipeline registers at the same rising edge.
- State, counters and `memTimeout` update on rising edge.
- Load-use costs exactly 1 bubble; taken branch costs 3 flushed slots; freeze lasts exactly the `memBusy`-high cycles.
- Reset (`reset_n` low at edge, including mid-FREEZE or mid-BUBBLE): state RUN, counters 0, busy counter 0, `memTimeout` 0. While `reset_n` low, outputs forced: `PCWrite=0`, `IFIDWrite=0`, `hazardMux=1`, flushes 1, `freeze=0`.

## Structure
- Shared package `processor_pkg`: state enum (RUN, BUBBLE, FLUSHED, FREEZE), `REG_W`, `CNT_W` defaults, `TIMEOUT` default.
- One sub-module: `sat_counter` (width-parameterized, sync active-low clear, increment enable, saturates), instantiated for `stallCount`, `flushCount` and the busy counter.

## Test plan
- Reset: hold `reset_n`=0 two cycles → forced outputs as listed, counters 0; release → RUN, `PCWrite=1`, `IFIDWrite=1`.
- Load-use: `memRead_IDEX`=1, `rt_IDEX`=3, `rs_IFID`=3 → one cycle `PCWrite=0`,`IFIDWrite=0`,`hazardMux=1`, `stallCount`=1; same stimulus held next cycle → no second bubble. Repeat with `rt_IDEX`=0 → no stall.
- Branch: `PCSrc_MEM`=1 one cycle with simultaneous load-use hit → three flushes 1, `PCWrite=1`, `flushCount`=1, `stallCount` unchanged; next cycle load-use suppressed.
- Freeze: `memBusy`=1 for 4 cycles with `PCSrc_MEM`=1 → `freeze`=1 for 4 cycles, no flushes; cycle after → flushes asserted, `flushCount`=1.
- Timeout/saturation: `memBusy`=1 for 256 cycles → `memTimeout`=1, stays 1 after `memBusy` drops; preload `stallCount` to 0xFFFF via 65535 hits → stays 0xFFFF on next hit.
- Reset mid-FREEZE: `reset_n`=0 during `memBusy` → state RUN, `memTimeout` 0, counters 0.
